// File: rtl/ats21_cmd_sched.sv
// ats21_cmd_sched: round-robin arbiter that serialises 32-bit ATS21 commands as two 16-bit beats and returns status or a timeout
module ats21_cmd_sched #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 64,
  localparam int IDW = $clog2(NUM_REQ)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [NUM_REQ*32-1:0]  req_instr,
  output logic [NUM_REQ-1:0]     req_grant,
  output logic                   resp_valid,
  output logic [IDW-1:0]         resp_id,
  output logic [1:0]             resp_stat,
  output logic                   resp_tmo,
  output logic                   busy,
  output logic                   ats_req,
  output logic [15:0]            ats_ctrl,
  input  logic                   ats_ready,
  input  logic [1:0]             ats_stat
);
  localparam int CW = $clog2(TIMEOUT);
  typedef enum logic [2:0] {IDLE, SEND_HI, SEND_LO, WAIT_RDY, RESP} state_t;
  state_t state, nxt;
  logic [IDW-1:0] ptr, win, id;
  logic found, take, last;
  logic [31:0] instr, instr_w;
  logic [CW-1:0] cnt;
  logic [1:0] stat;
  logic tmo;
  always_comb begin
    found = 1'b0;
    win = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (!found && req_valid[(int'(ptr) + i) % NUM_REQ]) begin
        found = 1'b1;
        win = IDW'((int'(ptr) + i) % NUM_REQ);
      end
  end
  // the grant is combinational, so it is masked while reset is held
  assign take = state == IDLE && found && reset;
  assign instr_w = req_instr[32*int'(win) +: 32];
  assign req_grant = take ? NUM_REQ'(1) << win : '0;
  assign last = cnt == CW'(TIMEOUT - 1);
  always_comb begin
    nxt = state;
    case (state)
      IDLE:     if (take) nxt = instr_w[31:29] == 3'b000 ? RESP : SEND_HI;
      SEND_HI:  nxt = SEND_LO;
      SEND_LO:  nxt = WAIT_RDY;
      WAIT_RDY: if (ats_ready || last) nxt = RESP;
      default:  nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      ptr <= '0;
      id <= '0;
      instr <= '0;
      cnt <= '0;
      stat <= '0;
      tmo <= 1'b0;
    end else begin
      state <= nxt;
      cnt <= state == WAIT_RDY && nxt == WAIT_RDY ? cnt + 1'b1 : '0;
      if (take) begin
        id <= win;
        instr <= instr_w;
        stat <= 2'b00;
        tmo <= 1'b0;
        ptr <= win == IDW'(NUM_REQ - 1) ? '0 : win + 1'b1;
      end
      // ready in the final timeout cycle still counts as a normal completion
      if (state == WAIT_RDY && ats_ready) begin
        stat <= ats_stat;
        tmo <= 1'b0;
      end else if (state == WAIT_RDY && last) begin
        stat <= 2'b11;
        tmo <= 1'b1;
      end
    end
  assign busy = state != IDLE;
  assign ats_req = state == SEND_HI || state == SEND_LO;
  assign ats_ctrl = state == SEND_HI ? instr[31:16] : state == SEND_LO ? instr[15:0] : '0;
  assign resp_valid = state == RESP;
  assign resp_id = resp_valid ? id : '0;
  assign resp_stat = resp_valid ? stat : '0;
  assign resp_tmo = resp_valid && tmo;
endmodule

// File: tb/tb_ats21_cmd_sched.sv
// tb_ats21_cmd_sched: scoreboard bench for grant order, beat serialisation, responses, timeout and reset
module tb_ats21_cmd_sched;
  localparam int TMO = 8;
  typedef struct {int id; logic [1:0] st; logic tmo; int cyc;} exp_t;
  logic clk = 0, reset = 0;
  logic [3:0] req_valid = '0;
  logic [127:0] req_instr = '0;
  logic [3:0] req_grant;
  logic resp_valid, resp_tmo, busy, ats_req, ats_ready = 0;
  logic [1:0] resp_id, resp_stat, ats_stat = '0;
  logic [15:0] ats_ctrl;
  int n_chk = 0, n_pass = 0, cyc = 0;
  exp_t exp_q[$];
  exp_t em;
  ats21_cmd_sched #(.NUM_REQ(4), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_instr(req_instr),
    .req_grant(req_grant), .resp_valid(resp_valid), .resp_id(resp_id),
    .resp_stat(resp_stat), .resp_tmo(resp_tmo), .busy(busy), .ats_req(ats_req),
    .ats_ctrl(ats_ctrl), .ats_ready(ats_ready), .ats_stat(ats_stat)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, want, cyc);
  endtask
  always @(negedge clk)
    if (resp_valid) begin
      if (exp_q.size() == 0) chk("resp_unexpected", 1, 0);
      else begin
        em = exp_q.pop_front();
        chk("resp_id", 32'(resp_id), em.id);
        chk("resp_stat", 32'(resp_stat), 32'(em.st));
        chk("resp_tmo", 32'(resp_tmo), 32'(em.tmo));
        chk("resp_cycle", cyc, em.cyc);
      end
    end
  task automatic wait_grant(input int id, output int g);
    int n = 0;
    logic [3:0] eg = 4'b0001 << id;
    @(negedge clk);
    while (req_grant == '0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("grant", 32'(req_grant), 32'(eg));
    g = cyc;
  endtask
  task automatic do_cmd(input int id, input int rdy, input logic [1:0] st);
    int g, rc;
    logic [31:0] ins = req_instr[32*id +: 32];
    logic [1:0] es;
    logic et;
    wait_grant(id, g);
    if (ins[31:29] == 3'b000) begin es = 2'b00; et = 1'b0; rc = g + 1; end
    else if (rdy >= 0 && rdy < TMO) begin es = st; et = 1'b0; rc = g + 4 + rdy; end
    else begin es = 2'b11; et = 1'b1; rc = g + 3 + TMO; end
    exp_q.push_back('{id, es, et, rc});
    @(posedge clk); #1;
    if (ins[31:29] == 3'b000) begin
      @(negedge clk);
      chk("nop_no_req", 32'(ats_req), 0);
    end else begin
      @(negedge clk);
      chk("hi_req", 32'(ats_req), 1);
      chk("hi_ctrl", 32'(ats_ctrl), 32'(ins[31:16]));
      @(posedge clk); #1;
      @(negedge clk);
      chk("lo_req", 32'(ats_req), 1);
      chk("lo_ctrl", 32'(ats_ctrl), 32'(ins[15:0]));
      for (int k = 0; k < TMO; k++) begin
        @(posedge clk); #1;
        ats_ready = k == rdy;
        ats_stat = st;
        if (k == rdy) break;
      end
      @(posedge clk); #1;
      ats_ready = 1'b0;
      ats_stat = '0;
      @(negedge clk);
    end
    @(posedge clk); #1;
  endtask
  initial begin
    int g;
    req_valid = 4'hF;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("reset_outputs", {req_grant, busy, ats_req, resp_valid, resp_tmo, resp_id, resp_stat, ats_ctrl}, 0);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    do_cmd(0, 0, 2'b00);
    req_valid = '0;
    req_instr[64 +: 32] = 32'h2A40_0000;
    req_valid = 4'b0100;
    do_cmd(2, 0, 2'b01);
    req_valid = '0;
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    for (int i = 0; i < 4; i++) req_instr[32*i +: 32] = 32'h2000_0000 | i;
    req_valid = 4'hF;
    for (int k = 0; k < 5; k++) do_cmd(k % 4, 0, 2'(k));
    req_valid = '0;
    req_instr[32 +: 32] = 32'h0000_FFFF;
    req_valid = 4'b0010;
    do_cmd(1, 0, 2'b10);
    req_valid = '0;
    req_instr[96 +: 32] = 32'h6000_0001;
    req_valid = 4'b1000;
    do_cmd(3, -1, 2'b01);
    do_cmd(3, TMO - 1, 2'b10);
    req_valid = '0;
    req_instr[96 +: 32] = 32'h4000_1234;
    req_valid = 4'b1000;
    wait_grant(3, g);
    @(posedge clk); #1;
    req_valid = '0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("lo_before_reset", 32'(ats_req), 1);
    #1 reset = 1'b0;
    #1 chk("reset_drops_req", 32'(ats_req), 0);
    chk("reset_idle", 32'(busy), 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    req_instr = '0;
    req_valid = 4'hF;
    do_cmd(0, 0, 2'b00);
    req_valid = '0;
    repeat (4) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule
